// File: rtl/posit_decoder_pipe.sv
// Two-stage posit decoder: unpacks a posit word into sign, regime k,
// exponent and right-aligned fraction, flagging zero and NaR.
module posit_decoder_pipe #(
  parameter  int N         = 16,
  parameter  int ES        = 1,
  parameter  int K_SIZE    = $clog2(N) + 1,
  parameter  int MANT_SIZE = N - 3 - ES,
  localparam int EW        = (ES > 0) ? ES : 1,
  localparam int FW        = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_posit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 is_zero,
  output logic                 is_nan,
  output logic                 sign,
  output logic [K_SIZE-1:0]    k,
`ifndef NO_ES_FIELD
  output logic [EW-1:0]        exp,
`endif
  output logic [MANT_SIZE-1:0] frac,
  output logic [FW-1:0]        frac_len
);

  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_sign_q, s1_sign_d;
  logic                 s1_zero_q, s1_zero_d;
  logic                 s1_nan_q, s1_nan_d;
  logic [N-1:0]         s1_mag_q, s1_mag_d;

  logic                 s2_valid_q, s2_valid_d;
  logic                 s2_sign_q, s2_sign_d;
  logic                 s2_zero_q, s2_zero_d;
  logic                 s2_nan_q, s2_nan_d;
  logic [K_SIZE-1:0]    s2_k_q, s2_k_d;
  logic [EW-1:0]        s2_exp_q, s2_exp_d;
  logic [MANT_SIZE-1:0] s2_frac_q, s2_frac_d;
  logic [FW-1:0]        s2_flen_q, s2_flen_d;

  logic [K_SIZE-1:0]    dec_k;
  logic [EW-1:0]        dec_exp;
  logic [MANT_SIZE-1:0] dec_frac;
  logic [FW-1:0]        dec_flen;

  logic s1_adv, s2_adv;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // stage 1: capture sign, special flags and magnitude
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_zero_d  = s1_zero_q;
    s1_nan_d   = s1_nan_q;
    s1_mag_d   = s1_mag_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d = in_posit[N-1];
        s1_zero_d = (in_posit == '0);
        s1_nan_d  = (in_posit == {1'b1, {(N-1){1'b0}}});
        s1_mag_d  = in_posit[N-1] ? -in_posit : in_posit;
      end
    end
  end

  // stage 2 decode: regime run length, exponent and fraction extraction
  always_comb begin
    logic                     r0;
    logic                     run;
    logic [N-1:0]             xs;
    logic [N+EW-1:0]          ext;
    logic [MANT_SIZE+N-1:0]   mw;
    logic [MANT_SIZE+N-1:0]   ones;
    int                       m;
    int                       rlen;
    int                       rem;
    int                       fl;
    r0   = s1_mag_q[N-2];
    xs   = r0 ? ~s1_mag_q : s1_mag_q;
    run  = 1'b1;
    m    = 0;
    for (int i = 0; i < N - 1; i++) begin
      if (run && !xs[N-2]) m = m + 1;
      else run = 1'b0;
      xs = xs << 1;
    end
    rlen = (m == N - 1) ? N - 1 : m + 1;
    rem  = N - 1 - rlen;
    fl   = (rem > ES) ? rem - ES : 0;
    ext  = {s1_mag_q, {EW{1'b0}}};
    mw   = {{MANT_SIZE{1'b0}}, s1_mag_q};
    ones = '1;
    ones = ones >> (MANT_SIZE + N - fl);
    dec_k    = r0 ? K_SIZE'(m - 1) : K_SIZE'(-m);
    dec_exp  = (ES > 0) ? EW'(ext >> rem) : '0;
    dec_frac = MANT_SIZE'(mw & ones);
    dec_flen = FW'(fl);
    if (s1_zero_q || s1_nan_q) begin
      dec_k    = '0;
      dec_exp  = '0;
      dec_frac = '0;
      dec_flen = '0;
    end
  end

  // stage 2 register load, held while downstream stalls
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_zero_d  = s2_zero_q;
    s2_nan_d   = s2_nan_q;
    s2_k_d     = s2_k_q;
    s2_exp_d   = s2_exp_q;
    s2_frac_d  = s2_frac_q;
    s2_flen_d  = s2_flen_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d = s1_sign_q && !s1_zero_q && !s1_nan_q;
        s2_zero_d = s1_zero_q;
        s2_nan_d  = s1_nan_q;
        s2_k_d    = dec_k;
        s2_exp_d  = dec_exp;
        s2_frac_d = dec_frac;
        s2_flen_d = dec_flen;
      end
    end
  end

  // pipeline state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_nan_q   <= 1'b0;
      s1_mag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_nan_q   <= 1'b0;
      s2_k_q     <= '0;
      s2_exp_q   <= '0;
      s2_frac_q  <= '0;
      s2_flen_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_zero_q  <= s1_zero_d;
      s1_nan_q   <= s1_nan_d;
      s1_mag_q   <= s1_mag_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_zero_q  <= s2_zero_d;
      s2_nan_q   <= s2_nan_d;
      s2_k_q     <= s2_k_d;
      s2_exp_q   <= s2_exp_d;
      s2_frac_q  <= s2_frac_d;
      s2_flen_q  <= s2_flen_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign is_zero   = s2_zero_q;
  assign is_nan    = s2_nan_q;
  assign sign      = s2_sign_q;
  assign k         = s2_k_q;
`ifndef NO_ES_FIELD
  assign exp       = s2_exp_q;
`endif
  assign frac      = s2_frac_q;
  assign frac_len  = s2_flen_q;

endmodule
